tt_vfp_encoder_seq: RTL
=======================

// Module: tt_vfp_encoder_seq
// PURPOSE
//  Sequences vector FP source operands into the recoding encoder. Accepts one operand group
//  per request (valid/ready), holds it, and issues 1 beat (non-widening, data_sel=0) or up to
//  2 beats (widening: upscale_lo sel=2, then upscale_hi sel=3) toward the encoder input,
//  with backpressure. Sits between the VFP issue queue and the encoder/FMA operand pipe.
// PARAMETERS
//  NUM_LANE  2  64-bit lanes per beat; must match the encoder instance
//  TAG_W     4  width of the opaque uop tag carried with every beat
//  NELEM_W   $clog2(NUM_LANE*4+1)  width of the active-element count
// PORTS
//  i_clk          in   1               clock
//  i_reset        in   1               asynchronous, active-high reset
//  i_req_valid    in   1               request valid
//  o_req_ready    out  1               request accepted when valid&ready
//  i_req_data     in   NUM_LANE*64     source operand group (lane i = bits 64i+:64)
//  i_req_widen    in   1               1: widening op (upscale), 0: same-width
//  i_req_sew      in   2               source SEW: 1=f16, 2=f32, 3=f64, 0=illegal
//  i_req_nelem    in   NELEM_W         active source elements in the group (0 = none)
//  i_req_tag      in   TAG_W           uop tag
//  o_enc_valid    out  1               beat valid toward encoder
//  i_enc_ready    in   1               downstream accepts beat
//  o_enc_data     out  NUM_LANE*64     held operand group (constant across beats of a request)
//  o_enc_sel      out  2               encoder data_sel: 0 same, 2 upscale_lo, 3 upscale_hi
//  o_enc_sew      out  2               source SEW of this beat
//  o_enc_tag      out  TAG_W           tag of this beat
//  o_enc_last     out  1               final beat of the request
//  o_busy         out  1               a request is held (state != IDLE)
//  o_err_illegal  out  1               1-cycle pulse on accepting an illegal request
// BEHAVIOUR
//  - Reset: state=IDLE; o_enc_valid=0, o_enc_sel=0, o_enc_sew=0, o_enc_tag=0, o_enc_last=0,
//    o_enc_data=0, o_busy=0, o_err_illegal=0. o_req_ready=1 combinationally in IDLE.
//  - States: IDLE, BEAT0, BEAT1. All enc outputs are registered. Accept-to-first-beat = 1 cycle.
//  - o_req_ready = IDLE | (o_enc_valid & i_enc_ready & o_enc_last), so back-to-back requests
//    stream with no bubble (1 beat/cycle for non-widening).
//  - Accept: capture data/sew/tag into the output regs; go to BEAT0, o_enc_valid=1.
//    widen=0: sel=0, last=1. widen=1: sel=2, last=skip_hi.
//    skip_hi = nelem <= NUM_LANE*(sew==1 ? 2 : 1) (hi half has no active elements).
//  - Illegal = sew==0 | (widen & sew==3). Accepted normally (ready honoured), o_err_illegal
//    pulses the cycle after the accept, and no beat is issued (stays/returns IDLE).
//  - nelem==0 is legal: one beat with last=1 is still issued (tag must retire).
//  - BEAT0 with valid&ready & !last: go to BEAT1, sel=3, last=1; data/sew/tag unchanged.
//  - BEAT0/BEAT1 with valid&ready & last: if a new request is accepted the same cycle,
//    load it (BEAT0), else IDLE and o_enc_valid=0.
//  - Without i_enc_ready, all enc outputs hold stable (AXI-style; valid never drops).
//  - i_reset asserted mid-request: the held request is discarded, no beats issued after release.
// STRUCTURE
//  - Package tt_vfp_pkg: typedef enum {SEL_SAME=2'd0, SEL_UP_LO=2'd2, SEL_UP_HI=2'd3} and the
//    SEW encoding (SEW_F16=1, SEW_F32=2, SEW_F64=3), shared with the encoder and decode.
//  - Single always_ff FSM + output regs; no sub-module. The encoder itself is instantiated
//    by the parent, not inside this block.
// TESTING
//  1 non-widen stream: 3 reqs sew=2, i_enc_ready=1 -> 3 beats on consecutive cycles, sel=0,
//    last=1, tags 1,2,3 in order.
//  2 widen full: widen=1 sew=1 nelem=8 (NUM_LANE=2) -> beat sel=2 last=0, then sel=3 last=1,
//    same data; o_req_ready=0 during the sel=2 beat.
//  3 widen skip: widen=1 sew=2 nelem=2 -> single beat sel=2 last=1; nelem=3 -> two beats.
//  4 backpressure: i_enc_ready=0 for 5 cycles during sel=2 -> outputs stable, then sel=3 on release.
//  5 illegal: widen=1 sew=3 -> accepted, o_err_illegal=1 for one cycle, no o_enc_valid.
//  6 reset mid-request: assert i_reset during BEAT1 -> all outputs 0 immediately, IDLE, ready=1.

Source files
------------

// File: rtl/tt_vfp_pkg.sv
// Shared encodings for the vector FP encoder path: encoder data_sel values and source SEW codes.
package tt_vfp_pkg;

  typedef enum logic [1:0] {
    SEL_SAME  = 2'd0,
    SEL_UP_LO = 2'd2,
    SEL_UP_HI = 2'd3
  } enc_sel_e;

  localparam logic [1:0] SEW_ILL = 2'd0;
  localparam logic [1:0] SEW_F16 = 2'd1;
  localparam logic [1:0] SEW_F32 = 2'd2;
  localparam logic [1:0] SEW_F64 = 2'd3;

  // Widening f64 has no destination format; SEW 0 is never valid.
  function automatic logic is_illegal(input logic widen, input logic [1:0] sew);
    return (sew == SEW_ILL) || (widen && (sew == SEW_F64));
  endfunction

endpackage

// File: rtl/tt_vfp_encoder_seq.sv
// Holds one vector FP operand group and issues it to the recoding encoder as one beat
// (same width) or up to two beats (widening lo/hi halves) with valid/ready backpressure.
module tt_vfp_encoder_seq
  import tt_vfp_pkg::*;
#(
  parameter int unsigned NUM_LANE = 2,
  parameter int unsigned TAG_W    = 4,
  parameter int unsigned NELEM_W  = $clog2(NUM_LANE * 4 + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic [NUM_LANE*64-1:0]  i_req_data,
  input  logic                    i_req_widen,
  input  logic [1:0]              i_req_sew,
  input  logic [NELEM_W-1:0]      i_req_nelem,
  input  logic [TAG_W-1:0]        i_req_tag,
  output logic                    o_enc_valid,
  input  logic                    i_enc_ready,
  output logic [NUM_LANE*64-1:0]  o_enc_data,
  output logic [1:0]              o_enc_sel,
  output logic [1:0]              o_enc_sew,
  output logic [TAG_W-1:0]        o_enc_tag,
  output logic                    o_enc_last,
  output logic                    o_busy,
  output logic                    o_err_illegal
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BEAT0 = 2'd1;
  localparam logic [1:0] ST_BEAT1 = 2'd2;

  localparam int unsigned LoCapF16 = NUM_LANE * 2;
  localparam int unsigned LoCapF32 = NUM_LANE;

  logic [1:0]              r_state;
  logic                    r_enc_valid;
  logic [NUM_LANE*64-1:0]  r_enc_data;
  enc_sel_e                r_enc_sel;
  logic [1:0]              r_enc_sew;
  logic [TAG_W-1:0]        r_enc_tag;
  logic                    r_enc_last;
  logic                    r_err_illegal;

  logic w_idle;
  logic w_beat_fire;
  logic w_accept;
  logic w_illegal;
  logic w_skip_hi;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_beat_fire = r_enc_valid && i_enc_ready;
  assign o_req_ready = w_idle || (w_beat_fire && r_enc_last);
  assign w_accept    = i_req_valid && o_req_ready;
  assign w_illegal   = is_illegal(i_req_widen, i_req_sew);

  // Hi half carries no active elements when all fit in the lo half after upscaling.
  always_comb begin
    w_skip_hi = 1'b0;
    if (i_req_sew == SEW_F16) begin
      w_skip_hi = (32'(i_req_nelem) <= LoCapF16);
    end else begin
      w_skip_hi = (32'(i_req_nelem) <= LoCapF32);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_enc_valid   <= 1'b0;
      r_enc_data    <= '0;
      r_enc_sel     <= SEL_SAME;
      r_enc_sew     <= '0;
      r_enc_tag     <= '0;
      r_enc_last    <= 1'b0;
      r_err_illegal <= 1'b0;
    end else begin
      r_err_illegal <= 1'b0;
      if (w_accept) begin
        if (w_illegal) begin
          r_err_illegal <= 1'b1;
          r_state       <= ST_IDLE;
          r_enc_valid   <= 1'b0;
        end else begin
          r_state     <= ST_BEAT0;
          r_enc_valid <= 1'b1;
          r_enc_data  <= i_req_data;
          r_enc_sew   <= i_req_sew;
          r_enc_tag   <= i_req_tag;
          if (i_req_widen) begin
            r_enc_sel  <= SEL_UP_LO;
            r_enc_last <= w_skip_hi;
          end else begin
            r_enc_sel  <= SEL_SAME;
            r_enc_last <= 1'b1;
          end
        end
      end else if (w_beat_fire) begin
        if (!r_enc_last) begin
          r_state    <= ST_BEAT1;
          r_enc_sel  <= SEL_UP_HI;
          r_enc_last <= 1'b1;
        end else begin
          r_state     <= ST_IDLE;
          r_enc_valid <= 1'b0;
        end
      end
    end
  end

  assign o_enc_valid   = r_enc_valid;
  assign o_enc_data    = r_enc_data;
  assign o_enc_sel     = r_enc_sel;
  assign o_enc_sew     = r_enc_sew;
  assign o_enc_tag     = r_enc_tag;
  assign o_enc_last    = r_enc_last;
  assign o_busy        = !w_idle;
  assign o_err_illegal = r_err_illegal;

endmodule
